uart_add_requester: RTL

- Initiator end of the 9-byte add-request / 5-byte add-response UART protocol. It is the host-side counterpart of the FPGA adder responder.
- Takes operands a, b and cin from a local start/done handshake. Serialises the request frame through an internal uart_tx, collects the response through an internal uart_rx, and presents sum/cout.
- Used as an on-FPGA test master for the responder board, replacing the external microcontroller.

---
 rtl/uart_add_requester.sv | 383 ++++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_add_requester.sv
// uart_add_requester: initiator side of the 9-byte add-request / 5-byte
// add-response UART protocol. Latches a, b, cin on i_start, serialises the
// request through an internal transmitter, collects the 5-byte response with
// an internal receiver and presents sum/cout with a one-cycle o_done.
// Optional result checker: define UART_ADD_REQUESTER_CHECK_EN to add o_mismatch.

// 8N1 transmitter: one byte per i_data_available, o_done pulses after the stop bit.
module uart_add_requester_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_data_available,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_done
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          r_done;

  // Bit-timing state machine; the line is driven from a register to stay glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx  <= 1'b1;
          r_cnt <= '0;
          r_bit <= '0;
          if (i_data_available) begin
            r_shift <= i_data;
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
            r_cnt   <= '0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
            r_cnt <= '0;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
            r_cnt   <= '0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign o_tx   = r_tx;
  assign o_done = r_done;
endmodule

// 8N1 receiver: o_data_available rises mid stop bit and stays high until the
// next start bit is seen, so consumers must edge-detect it.
module uart_add_requester_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx,
  output logic       o_data_available,
  output logic [7:0] o_data
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_dv;
  logic          r_rx_m;
  logic          r_rx_s;

  // Two-flop synchroniser for the asynchronous serial input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_m <= 1'b1;
      r_rx_s <= 1'b1;
    end else begin
      r_rx_m <= i_rx;
      r_rx_s <= r_rx_m;
    end
  end

  // Mid-bit sampling state machine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_dv    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          r_bit <= '0;
          if (!r_rx_s) begin
            r_dv    <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (r_cnt == CW'((CLKS_PER_BIT - 1) / 2)) begin
            r_cnt   <= '0;
            r_state <= r_rx_s ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
            r_cnt   <= '0;
            r_shift <= {r_rx_s, r_shift[7:1]};
            if (r_bit == 3'd7) r_state <= S_STOP;
            else               r_bit   <= r_bit + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
            r_cnt   <= '0;
            r_dv    <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign o_data_available = r_dv;
  assign o_data           = r_shift;
endmodule

module uart_add_requester #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_CLKS = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  input  logic        i_uart_rx,
  output logic        o_uart_tx,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_sum,
  output logic        o_cout,
  output logic        o_timeout
`ifdef UART_ADD_REQUESTER_CHECK_EN
  ,
  output logic        o_mismatch
`endif
);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] TX_LOAD = 3'd1;
  localparam logic [2:0] TX_WAIT = 3'd2;
  localparam logic [2:0] RX_WAIT = 3'd3;
  localparam logic [2:0] FINISH  = 3'd4;

  logic [2:0]    r_state;
  logic [31:0]   r_a;
  logic [31:0]   r_b;
  logic          r_cin;
  logic [3:0]    r_tx_idx;
  logic [2:0]    r_rx_idx;
  logic [TW-1:0] r_tmo_cnt;
  logic [31:0]   r_sh_sum;
  logic          r_sh_cout;
  logic          r_rx_dv_q;
  logic          r_busy;
  logic          r_done;
  logic [31:0]   r_sum;
  logic          r_cout;
  logic          r_timeout;

  logic          w_tx_dv;
  logic [7:0]    w_tx_byte;
  logic          w_tx_done;
  logic          w_rx_dv;
  logic [7:0]    w_rx_byte;
  logic          w_rx_rise;

  uart_add_requester_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_data_available (w_tx_dv),
    .i_data           (w_tx_byte),
    .o_tx             (o_uart_tx),
    .o_done           (w_tx_done)
  );

  uart_add_requester_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_rx             (i_uart_rx),
    .o_data_available (w_rx_dv),
    .o_data           (w_rx_byte)
  );

  assign w_tx_dv   = (r_state == TX_LOAD);
  assign w_rx_rise = w_rx_dv & ~r_rx_dv_q;

  // Request frame byte selection: a then b, LSB first, then carry-in.
  always_comb begin
    w_tx_byte = 8'h00;
    case (r_tx_idx)
      4'd0:    w_tx_byte = r_a[7:0];
      4'd1:    w_tx_byte = r_a[15:8];
      4'd2:    w_tx_byte = r_a[23:16];
      4'd3:    w_tx_byte = r_a[31:24];
      4'd4:    w_tx_byte = r_b[7:0];
      4'd5:    w_tx_byte = r_b[15:8];
      4'd6:    w_tx_byte = r_b[23:16];
      4'd7:    w_tx_byte = r_b[31:24];
      default: w_tx_byte = {7'b0, r_cin};
    endcase
  end

`ifdef UART_ADD_REQUESTER_CHECK_EN
  logic        r_b0_hi;
  logic        r_mismatch;
  logic [32:0] w_expect;

  // Reference result from the latched operands.
  function automatic logic [32:0] add33(input logic [31:0] a, input logic [31:0] b,
                                        input logic cin);
    add33 = {1'b0, a} + {1'b0, b} + {32'b0, cin};
  endfunction

  assign w_expect = add33(r_a, r_b, r_cin);

  // Checker: response byte 0 upper bits and final comparison against the reference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b0_hi    <= 1'b0;
      r_mismatch <= 1'b0;
    end else begin
      if (r_state == IDLE && i_start) r_mismatch <= 1'b0;
      if (r_state == RX_WAIT && w_rx_rise && r_rx_idx == 3'd0) r_b0_hi <= |w_rx_byte[7:1];
      if (r_state == FINISH)
        r_mismatch <= !r_timeout && (({r_sh_cout, r_sh_sum} != w_expect) || r_b0_hi);
    end
  end

  assign o_mismatch = r_mismatch;
`endif

  // Transaction sequencer: request, response collection, timeout and completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_cin     <= 1'b0;
      r_tx_idx  <= '0;
      r_rx_idx  <= '0;
      r_tmo_cnt <= '0;
      r_sh_sum  <= '0;
      r_sh_cout <= 1'b0;
      r_rx_dv_q <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_rx_dv_q <= w_rx_dv;
      r_done    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_a       <= i_a;
            r_b       <= i_b;
            r_cin     <= i_cin;
            r_timeout <= 1'b0;
            r_busy    <= 1'b1;
            r_tx_idx  <= '0;
            r_state   <= TX_LOAD;
          end
        end
        TX_LOAD: r_state <= TX_WAIT;
        TX_WAIT: begin
          if (w_tx_done) begin
            if (r_tx_idx == 4'd8) begin
              r_rx_idx  <= '0;
              r_tmo_cnt <= '0;
              r_state   <= RX_WAIT;
            end else begin
              r_tx_idx <= r_tx_idx + 1'b1;
              r_state  <= TX_LOAD;
            end
          end
        end
        RX_WAIT: begin
          if (w_rx_rise) begin
            r_tmo_cnt <= '0;
            r_rx_idx  <= r_rx_idx + 1'b1;
            case (r_rx_idx)
              3'd0:    r_sh_cout       <= w_rx_byte[0];
              3'd1:    r_sh_sum[7:0]   <= w_rx_byte;
              3'd2:    r_sh_sum[15:8]  <= w_rx_byte;
              3'd3:    r_sh_sum[23:16] <= w_rx_byte;
              default: r_sh_sum[31:24] <= w_rx_byte;
            endcase
            if (r_rx_idx == 3'd4) r_state <= FINISH;
          end else if (r_tmo_cnt == TW'(TIMEOUT_CLKS - 1)) begin
            r_timeout <= 1'b1;
            r_state   <= FINISH;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        default: begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
          if (!r_timeout) begin
            r_sum  <= r_sh_sum;
            r_cout <= r_sh_cout;
          end
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_sum     = r_sum;
  assign o_cout    = r_cout;
  assign o_timeout = r_timeout;
endmodule
